// File: rtl/cond_pkg.sv
// Shared condition-path types: flag vector layout and the {valid, flags} pending entry.
// Used by flag_register_unit and condition_checker.
package cond_pkg;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;
    localparam int FLAGS_BITS = 4;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    typedef struct packed {
        logic   valid;
        flags_t flags;
    } flag_entry_t;

    localparam flag_entry_t FLAG_ENTRY_EMPTY = '{valid: 1'b0, flags: '0};

    // Youngest pending write wins; fall back to the committed flags.
    function automatic flags_t fwd_select(flag_entry_t m, flag_entry_t w, flags_t arch);
        flags_t sel;
        if (m.valid)
            sel = m.flags;
        else if (w.valid)
            sel = w.flags;
        else
            sel = arch;
        return sel;
    endfunction

endpackage

// File: rtl/flag_stage_reg.sv
// One pending-flag pipeline slot: a {valid, flags} register with clear, load and hold.
// Clear dominates load so a kill always empties the slot even when it would advance.
module flag_stage_reg
    import cond_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_load,
    input  flag_entry_t i_d,
    output flag_entry_t o_q
);

    flag_entry_t r_entry;

    always_ff @(posedge clk) begin
        if (!rst)
            r_entry <= FLAG_ENTRY_EMPTY;
        else if (i_clear)
            r_entry <= FLAG_ENTRY_EMPTY;
        else if (i_load)
            r_entry <= i_d;
    end

    assign o_q = r_entry;

endmodule

// File: rtl/flag_register_unit.sv
// Architectural N/Z/C/V register with two pending stages (M, W) and forwarding to the
// condition checker; flags commit from W and only registered state drives the outputs.
module flag_register_unit
    import cond_pkg::*;
#(
    parameter int FLAG_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_e,
    input  logic              FlagW_e,
    input  logic              CondEx_e,
    input  logic [FLAG_W-1:0] ALUFlags_e,
    input  logic              stall,
    input  logic              flush_m,
    output logic [FLAG_W-1:0] Flags,
    output logic [FLAG_W-1:0] ArchFlags,
    output logic              pending
);

    logic        w_wr_e;
    logic        w_advance;
    flag_entry_t w_entry_e;
    flag_entry_t w_entry_m;
    flag_entry_t w_entry_w;
    flags_t      w_fwd;
    flags_t      r_arch;

    assign w_wr_e    = valid_e & FlagW_e & CondEx_e;
    assign w_advance = ~stall;
    assign w_entry_e = '{valid: w_wr_e, flags: flags_t'(ALUFlags_e)};

    // A flush empties M even under stall; W keeps the older instruction's write.
    flag_stage_reg u_stage_m (
        .clk     (clk),
        .rst     (rst),
        .i_clear (flush_m),
        .i_load  (w_advance),
        .i_d     (w_entry_e),
        .o_q     (w_entry_m)
    );

    flag_stage_reg u_stage_w (
        .clk     (clk),
        .rst     (rst),
        .i_clear (1'b0),
        .i_load  (w_advance),
        .i_d     (w_entry_m),
        .o_q     (w_entry_w)
    );

    always_ff @(posedge clk) begin
        if (!rst)
            r_arch <= '0;
        else if (w_advance && w_entry_w.valid)
            r_arch <= w_entry_w.flags;
    end

    assign w_fwd     = fwd_select(w_entry_m, w_entry_w, r_arch);
    assign Flags     = w_fwd;
    assign ArchFlags = r_arch;
    assign pending   = w_entry_m.valid | w_entry_w.valid;

endmodule

// File: tb/tb_flag_register_unit.sv
// Scoreboard bench for flag_register_unit: directed cycles push hand-computed
// {Flags, ArchFlags, pending} into a queue; a negedge monitor pops and compares.
module tb_flag_register_unit;

    logic       clk;
    logic       rst;
    logic       valid_e;
    logic       FlagW_e;
    logic       CondEx_e;
    logic [3:0] ALUFlags_e;
    logic       stall;
    logic       flush_m;
    logic [3:0] Flags;
    logic [3:0] ArchFlags;
    logic       pending;

    typedef struct {
        string      name;
        logic [3:0] f;
        logic [3:0] a;
        logic       p;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp;
    int   n_bad;
    bit   stim_done;

    flag_register_unit #(.FLAG_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_e    (valid_e),
        .FlagW_e    (FlagW_e),
        .CondEx_e   (CondEx_e),
        .ALUFlags_e (ALUFlags_e),
        .stall      (stall),
        .flush_m    (flush_m),
        .Flags      (Flags),
        .ArchFlags  (ArchFlags),
        .pending    (pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle, then queue what the outputs must be after that edge.
    task automatic cyc(input string name, input logic r, input logic v, input logic fw,
                       input logic ce, input logic [3:0] alu, input logic st, input logic fl,
                       input logic [3:0] ef, input logic [3:0] ea, input logic ep);
        exp_t e;
        rst = r; valid_e = v; FlagW_e = fw; CondEx_e = ce;
        ALUFlags_e = alu; stall = st; flush_m = fl;
        @(posedge clk);
        e.name = name; e.f = ef; e.a = ea; e.p = ep;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic wr(input string name, input logic [3:0] alu,
                      input logic [3:0] ef, input logic [3:0] ea, input logic ep);
        cyc(name, 1'b1, 1'b1, 1'b1, 1'b1, alu, 1'b0, 1'b0, ef, ea, ep);
    endtask

    task automatic idle(input string name,
                        input logic [3:0] ef, input logic [3:0] ea, input logic ep);
        cyc(name, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, ef, ea, ep);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_cmp = n_cmp + 1;
            if (Flags !== e.f) begin
                n_bad = n_bad + 1;
                $display("FAIL %s Flags: got %b want %b", e.name, Flags, e.f);
            end
            n_cmp = n_cmp + 1;
            if (ArchFlags !== e.a) begin
                n_bad = n_bad + 1;
                $display("FAIL %s ArchFlags: got %b want %b", e.name, ArchFlags, e.a);
            end
            n_cmp = n_cmp + 1;
            if (pending !== e.p) begin
                n_bad = n_bad + 1;
                $display("FAIL %s pending: got %b want %b", e.name, pending, e.p);
            end
        end
    end

    initial begin
        n_cmp = 0; n_bad = 0; stim_done = 1'b0;
        rst = 1'b0; valid_e = 1'b1; FlagW_e = 1'b1; CondEx_e = 1'b1;
        ALUFlags_e = 4'b1111; stall = 1'b0; flush_m = 1'b0;

        // Reset holds everything at zero despite a live writer on the inputs.
        for (int i = 0; i < 3; i++)
            cyc("reset", 1'b0, 1'b1, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        idle("post_reset", 4'b0000, 4'b0000, 1'b0);

        // Single compare: M at n+1, W at n+2, committed at n+3.
        wr  ("single_m",  4'b0100, 4'b0100, 4'b0000, 1'b1);
        idle("single_w",  4'b0100, 4'b0000, 1'b1);
        idle("single_c",  4'b0100, 4'b0100, 1'b0);
        idle("single_h",  4'b0100, 4'b0100, 1'b0);

        // Back-to-back writers: youngest forwarded, commits in order.
        wr  ("b2b_0",     4'b0011, 4'b0011, 4'b0100, 1'b1);
        wr  ("b2b_1",     4'b1001, 4'b1001, 4'b0100, 1'b1);
        idle("b2b_c0",    4'b1001, 4'b0011, 1'b1);
        idle("b2b_c1",    4'b1001, 4'b1001, 1'b0);

        // Instructions that must not write.
        cyc("squash_cond", 1'b1, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b0, 4'b1001, 4'b1001, 1'b0);
        cyc("squash_valid",1'b1, 1'b0, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, 4'b1001, 4'b1001, 1'b0);
        cyc("not_setting", 1'b1, 1'b1, 1'b0, 1'b1, 4'b1111, 1'b0, 1'b0, 4'b1001, 4'b1001, 1'b0);
        idle("squash_h",  4'b1001, 4'b1001, 1'b0);

        // Flush kills the write entering M.
        cyc("flush_new",   1'b1, 1'b1, 1'b1, 1'b1, 4'b1000, 1'b0, 1'b1, 4'b1001, 4'b1001, 1'b0);
        idle("flush_new1", 4'b1001, 4'b1001, 1'b0);
        idle("flush_new2", 4'b1001, 4'b1001, 1'b0);

        // Flush with an older entry in M: that entry still commits.
        wr  ("flush_old0", 4'b0110, 4'b0110, 4'b1001, 1'b1);
        cyc("flush_old1",  1'b1, 1'b1, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b1, 4'b0110, 4'b1001, 1'b1);
        idle("flush_old2", 4'b0110, 4'b0110, 1'b0);

        // Stall freezes M/W/Arch and ignores the E input.
        wr  ("stall_w",    4'b0010, 4'b0010, 4'b0110, 1'b1);
        for (int i = 0; i < 3; i++)
            cyc("stall_hold", 1'b1, 1'b1, 1'b1, 1'b1, 4'b1111, 1'b1, 1'b0, 4'b0010, 4'b0110, 1'b1);
        idle("stall_rel0", 4'b0010, 4'b0110, 1'b1);
        idle("stall_rel1", 4'b0010, 4'b0010, 1'b0);

        // Flush under stall: M cleared, W and Arch hold.
        wr  ("sf_0",       4'b0101, 4'b0101, 4'b0010, 1'b1);
        wr  ("sf_1",       4'b1100, 4'b1100, 4'b0010, 1'b1);
        cyc("sf_stflush",  1'b1, 1'b1, 1'b1, 1'b1, 4'b0001, 1'b1, 1'b1, 4'b0101, 4'b0010, 1'b1);
        idle("sf_commit",  4'b0101, 4'b0101, 1'b0);

        // Reset mid-flight discards the pending write.
        wr  ("rst_mid0",   4'b1110, 4'b1110, 4'b0101, 1'b1);
        idle("rst_mid1",   4'b1110, 4'b0101, 1'b1);
        cyc("rst_mid2",    1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        idle("rst_mid3",   4'b0000, 4'b0000, 1'b0);
        idle("rst_mid4",   4'b0000, 4'b0000, 1'b0);

        stim_done = 1'b1;
    end

    initial begin
        wait (stim_done);
        for (int i = 0; i < 20 && exp_q.size() > 0; i++)
            @(posedge clk);
        if (exp_q.size() > 0) begin
            n_cmp = n_cmp + 1;
            n_bad = n_bad + 1;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: stimulus did not finish, want completion");
        $fatal(1, "timeout");
    end

endmodule
